// File: rtl/hpdcache_pf_responder.sv
// Prefetch request terminator: queues prefetcher requests, issues one cacheline
// refill per valid CMO prefetch and answers the prefetcher once it is accepted.
package hpdcache_pf_pkg;
  localparam int unsigned HPDCACHE_OFFSET_WIDTH = 6;
  localparam int unsigned HPDCACHE_SET_WIDTH    = 6;
  localparam int unsigned HPDCACHE_TAG_WIDTH    = 20;
  localparam int unsigned HPDCACHE_NLINE_WIDTH  = HPDCACHE_TAG_WIDTH + HPDCACHE_SET_WIDTH;
  localparam int unsigned HPDCACHE_WORD_WIDTH   = 64;
  localparam int unsigned HPDCACHE_SID_WIDTH    = 3;
  localparam int unsigned HPDCACHE_TID_WIDTH    = 4;

  typedef logic [3:0]                      hpdcache_req_op_t;
  typedef logic [2:0]                      hpdcache_req_size_t;
  typedef logic [HPDCACHE_NLINE_WIDTH-1:0] hpdcache_nline_t;

  localparam hpdcache_req_op_t   HPDCACHE_REQ_LOAD             = 4'h0;
  localparam hpdcache_req_op_t   HPDCACHE_REQ_STORE            = 4'h1;
  localparam hpdcache_req_op_t   HPDCACHE_REQ_CMO              = 4'hf;
  localparam hpdcache_req_size_t HPDCACHE_REQ_CMO_PREFETCH     = 3'h0;
  localparam hpdcache_req_size_t HPDCACHE_REQ_CMO_INVAL_NLINE  = 3'h1;

  typedef struct packed {
    logic [HPDCACHE_OFFSET_WIDTH+HPDCACHE_SET_WIDTH-1:0] addr_offset;
    logic [HPDCACHE_WORD_WIDTH-1:0]                      wdata;
    hpdcache_req_op_t                                    op;
    logic [HPDCACHE_WORD_WIDTH/8-1:0]                    be;
    hpdcache_req_size_t                                  size;
    logic [HPDCACHE_SID_WIDTH-1:0]                       sid;
    logic [HPDCACHE_TID_WIDTH-1:0]                       tid;
    logic                                                need_rsp;
    logic [HPDCACHE_TAG_WIDTH-1:0]                       addr_tag;
  } hpdcache_req_t;

  typedef struct packed {
    logic [HPDCACHE_WORD_WIDTH-1:0] rdata;
    logic [HPDCACHE_SID_WIDTH-1:0]  sid;
    logic [HPDCACHE_TID_WIDTH-1:0]  tid;
    logic                           error;
    logic                           aborted;
  } hpdcache_rsp_t;
endpackage

module hpdcache_pf_responder
  import hpdcache_pf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RSP_DELAY  = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  hpdcache_req_t   req_i,
  output logic            rsp_valid_o,
  output hpdcache_rsp_t   rsp_o,
  output logic            refill_valid_o,
  input  logic            refill_ready_i,
  output hpdcache_nline_t refill_nline_o,
  output logic            busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DLY_W = (RSP_DELAY > 1) ? $clog2(RSP_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_INIT = (RSP_DELAY > 0) ? DLY_W'(RSP_DELAY - 1) : '0;

  typedef struct packed {
    hpdcache_nline_t               nline;
    logic [HPDCACHE_SID_WIDTH-1:0] sid;
    logic [HPDCACHE_TID_WIDTH-1:0] tid;
    logic                          need_rsp;
    logic                          is_pf;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;

  entry_t push_entry;
  entry_t head;
  logic   full, empty, push, pop;

  assign full        = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (cnt_q == '0);
  assign req_ready_o = !full;
  assign push        = req_valid_i && !full;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    push_entry.nline    = {req_i.addr_tag,
                           req_i.addr_offset[HPDCACHE_OFFSET_WIDTH +: HPDCACHE_SET_WIDTH]};
    push_entry.sid      = req_i.sid;
    push_entry.tid      = req_i.tid;
    push_entry.need_rsp = req_i.need_rsp;
    push_entry.is_pf    = (req_i.op == HPDCACHE_REQ_CMO) &&
                          (req_i.size == HPDCACHE_REQ_CMO_PREFETCH);
  end

  // Entry storage carries no reset: validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    dly_d          = dly_q;
    pop            = 1'b0;
    refill_valid_o = 1'b0;
    rsp_valid_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = head.is_pf ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        refill_valid_o = 1'b1;
        if (refill_ready_i) begin
          if (RSP_DELAY == 0) begin
            state_d = ST_RESP;
          end else begin
            dly_d   = DLY_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dly_q == '0) state_d = ST_RESP;
        else             dly_d   = dly_q - 1'b1;
      end
      ST_RESP: begin
        rsp_valid_o = head.need_rsp;
        pop         = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      dly_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      dly_q    <= dly_d;
    end
  end

  // Head nline is presented continuously; it only qualifies as a refill in ISSUE.
  assign refill_nline_o = head.nline;

  always_comb begin
    rsp_o       = '0;
    rsp_o.sid   = head.sid;
    rsp_o.tid   = head.tid;
    rsp_o.error = !head.is_pf;
  end

  assign busy_o = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_hpdcache_pf_responder.sv
// Directed bench for hpdcache_pf_responder: one instance with RSP_DELAY=0 and
// one with RSP_DELAY=3 share the request and refill-ready stimulus.
module tb_hpdcache_pf_responder;
  import hpdcache_pf_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid;
  hpdcache_req_t   req;
  logic            refill_ready;

  logic            req_ready0, rsp_valid0, refill_valid0, busy0;
  hpdcache_rsp_t   rsp0;
  hpdcache_nline_t nline0;
  logic            req_ready3, rsp_valid3, refill_valid3, busy3;
  hpdcache_rsp_t   rsp3;
  hpdcache_nline_t nline3;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp0_cnt = 0;
  int rsp3_cnt = 0;
  hpdcache_nline_t refill_log [$];

  always #5 clk = ~clk;

  hpdcache_pf_responder #(.FIFO_DEPTH(4), .RSP_DELAY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready0), .req_i(req),
    .rsp_valid_o(rsp_valid0), .rsp_o(rsp0),
    .refill_valid_o(refill_valid0), .refill_ready_i(refill_ready),
    .refill_nline_o(nline0), .busy_o(busy0)
  );

  hpdcache_pf_responder #(.FIFO_DEPTH(4), .RSP_DELAY(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready3), .req_i(req),
    .rsp_valid_o(rsp_valid3), .rsp_o(rsp3),
    .refill_valid_o(refill_valid3), .refill_ready_i(refill_ready),
    .refill_nline_o(nline3), .busy_o(busy3)
  );

  always @(negedge clk) begin
    if (rsp_valid0) rsp0_cnt++;
    if (rsp_valid3) rsp3_cnt++;
    if (refill_valid0 && refill_ready) refill_log.push_back(nline0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic hpdcache_nline_t mk_nline(input int tag, input int set);
    return {20'(tag), 6'(set)};
  endfunction

  task automatic set_req(input int tag, input int set, input int tid,
                         input hpdcache_req_op_t op, input hpdcache_req_size_t size,
                         input logic nr);
    req             = '0;
    req.addr_tag    = 20'(tag);
    req.addr_offset = {6'(set), 6'b0};
    req.tid         = 4'(tid);
    req.sid         = 3'd1;
    req.op          = op;
    req.size        = size;
    req.need_rsp    = nr;
    req_valid       = 1'b1;
    $display("req tag=0x%0h set=0x%0h tid=%0d op=0x%0h size=%0d need_rsp=%0b",
             tag, set, tid, op, size, nr);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (busy0 || busy3); i++) step();
    check("idle_timeout", 64'(busy0 | busy3), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c3, nlog;
    hpdcache_nline_t exp_nl [4];
    req_valid    = 1'b0;
    req          = '0;
    refill_ready = 1'b1;
    repeat (3) step();
    check("rst_rsp_valid",    64'(rsp_valid0),    64'd0);
    check("rst_refill_valid", 64'(refill_valid0), 64'd0);
    check("rst_busy",         64'(busy0),         64'd0);
    check("rst_req_ready",    64'(req_ready0),    64'd1);
    rst_n = 1'b1;
    step();

    // Single prefetch: refill at N+2, response at N+3 (delay 0) / N+6 (delay 3)
    set_req(32'h12, 3, 5, HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, 1'b1);
    check("t1_ready", 64'(req_ready0), 64'd1);
    step();
    req_valid = 1'b0;
    check("t1_n1_refill", 64'(refill_valid0), 64'd0);
    step();
    check("t1_n2_refill",  64'(refill_valid0), 64'd1);
    check("t1_n2_nline",   64'(nline0),        64'(mk_nline(32'h12, 3)));
    check("t1_n2_rsp",     64'(rsp_valid0),    64'd0);
    check("t1_n2_refill3", 64'(refill_valid3), 64'd1);
    step();
    check("t1_n3_rsp",    64'(rsp_valid0),    64'd1);
    check("t1_n3_tid",    64'(rsp0.tid),      64'd5);
    check("t1_n3_sid",    64'(rsp0.sid),      64'd1);
    check("t1_n3_error",  64'(rsp0.error),    64'd0);
    check("t1_n3_refill", 64'(refill_valid0), 64'd0);
    for (int k = 3; k <= 7; k++) begin
      check($sformatf("t2_rsp3_n%0d", k),  64'(rsp_valid3), 64'(k == 6));
      check($sformatf("t2_busy3_n%0d", k), 64'(busy3),      64'(k != 7));
      if (k < 7) step();
    end
    check("t2_rsp3_count", 64'(rsp3_cnt), 64'd1);
    check("t1_rsp0_count", 64'(rsp0_cnt), 64'd1);
    wait_idle();

    // Fill the queue under refill stall, then drain in order every 3 cycles
    refill_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(32'h20 + i, 8 + i, i, HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, 1'b1);
      exp_nl[i] = mk_nline(32'h20 + i, 8 + i);
      check($sformatf("t3_ready_push%0d", i), 64'(req_ready0), 64'd1);
      step();
    end
    req_valid = 1'b0;
    check("t3_full_ready0", 64'(req_ready0), 64'd0);
    check("t3_full_ready3", 64'(req_ready3), 64'd0);
    step();
    step();
    check("t3_stall_valid", 64'(refill_valid0), 64'd1);
    check("t3_stall_nline", 64'(nline0),        64'(exp_nl[0]));
    refill_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t3_refill_k%0d", k), 64'(refill_valid0), 64'(k % 3 == 0));
      if (k % 3 == 0) check($sformatf("t3_nline_k%0d", k), 64'(nline0), 64'(exp_nl[k / 3]));
      if (k == 1) check("t3_ready_pop", 64'(req_ready0), 64'd0);
      if (k == 2) check("t3_ready_pop1", 64'(req_ready0), 64'd1);
      step();
    end
    wait_idle();

    // Non-prefetch ops take the error path with no refill
    nlog = refill_log.size();
    set_req(32'h30, 1, 7, HPDCACHE_REQ_LOAD, 3'h0, 1'b1);
    step();
    req_valid = 1'b0;
    check("t4_load_n1_refill", 64'(refill_valid0), 64'd0);
    step();
    check("t4_load_rsp",    64'(rsp_valid0),    64'd1);
    check("t4_load_error",  64'(rsp0.error),    64'd1);
    check("t4_load_tid",    64'(rsp0.tid),      64'd7);
    check("t4_load_refill", 64'(refill_valid0), 64'd0);
    step();
    check("t4_load_busy", 64'(busy0), 64'd0);
    check("t4_load_nolog", 64'(refill_log.size()), 64'(nlog));
    set_req(32'h32, 3, 9, HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_INVAL_NLINE, 1'b1);
    step();
    req_valid = 1'b0;
    step();
    check("t4_cmo_rsp",   64'(rsp_valid0), 64'd1);
    check("t4_cmo_error", 64'(rsp0.error), 64'd1);
    wait_idle();

    // Prefetch with need_rsp=0: refill still issued, no response pulse
    c0 = rsp0_cnt;
    set_req(32'h31, 2, 8, HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    check("t4_norsp_refill", 64'(refill_valid0), 64'd1);
    check("t4_norsp_nline",  64'(nline0),        64'(mk_nline(32'h31, 2)));
    step();
    check("t4_norsp_rsp",  64'(rsp_valid0), 64'd0);
    check("t4_norsp_busy", 64'(busy0),      64'd1);
    step();
    check("t4_norsp_idle", 64'(busy0),    64'd0);
    check("t4_norsp_cnt",  64'(rsp0_cnt), 64'(c0));
    wait_idle();

    // Push and pop in the same cycle at 3/4 full, across the pointer wrap
    set_req(32'h40, 0, 0, HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, 1'b1);
    step();
    req_valid = 1'b0;
    wait_idle();
    refill_log.delete();
    c0 = rsp0_cnt;
    refill_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(32'h41 + i, 16 + i, i, HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, 1'b1);
      exp_nl[i] = mk_nline(32'h41 + i, 16 + i);
      step();
    end
    req_valid = 1'b0;
    step();
    check("t5_cnt_before", 64'(dut0.cnt_q), 64'd3);
    refill_ready = 1'b1;
    step();
    set_req(32'h44, 19, 3, HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, 1'b1);
    exp_nl[3] = mk_nline(32'h44, 19);
    check("t5_pop_rsp", 64'(rsp_valid0), 64'd1);
    step();
    req_valid = 1'b0;
    check("t5_cnt_pushpop", 64'(dut0.cnt_q), 64'd3);
    wait_idle();
    check("t5_refill_count", 64'(refill_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < refill_log.size(); i++)
      check($sformatf("t5_order%0d", i), 64'(refill_log[i]), 64'(exp_nl[i]));
    check("t5_rsp_count", 64'(rsp0_cnt - c0), 64'd4);

    // Reset while in ISSUE with two entries queued
    refill_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(32'h50 + i, 20 + i, i, HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, 1'b1);
      step();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !refill_valid0; i++) step();
    check("t6_in_issue", 64'(refill_valid0), 64'd1);
    c0   = rsp0_cnt;
    c3   = rsp3_cnt;
    nlog = refill_log.size();
    rst_n = 1'b0;
    #1;
    check("t6_async_refill0", 64'(refill_valid0), 64'd0);
    check("t6_async_refill3", 64'(refill_valid3), 64'd0);
    check("t6_async_rsp0",    64'(rsp_valid0),    64'd0);
    check("t6_async_busy0",   64'(busy0),         64'd0);
    step();
    refill_ready = 1'b1;
    rst_n = 1'b1;
    step();
    check("t6_busy0",  64'(busy0),      64'd0);
    check("t6_busy3",  64'(busy3),      64'd0);
    check("t6_ready0", 64'(req_ready0), 64'd1);
    repeat (10) step();
    check("t6_no_rsp0",    64'(rsp0_cnt),          64'(c0));
    check("t6_no_rsp3",    64'(rsp3_cnt),          64'(c3));
    check("t6_no_refill",  64'(refill_log.size()), 64'(nlog));
    check("t6_refill_low", 64'(refill_valid0),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
